// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control codes, HI/LO unit state encoding and iteration-count helper.
// The MULT_ACCUM_EN build option lives in hilo_mult_unit; nothing here depends on it.
package alu_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_MULT  = 5'b00011;
    localparam logic [4:0] ALU_MULTU = 5'b00100;
    localparam logic [4:0] ALU_MUL   = 5'b10011;
    localparam logic [4:0] ALU_MADD  = 5'b10100;
    localparam logic [4:0] ALU_MSUB  = 5'b10101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } hilo_state_e;

    function automatic int calc_iter(input int bits_per_cycle);
        return 32 / bits_per_cycle;
    endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Iterative unsigned 32x32->64 shift-add multiplier retiring BITS_PER_CYCLE
// multiplier bits per step; 'last' is high during the final step.
module mult_shift_add_core
    import alu_ctrl_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod,
    output logic        last
);
    localparam int ITER = calc_iter(BITS_PER_CYCLE);

    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  count;
    logic [63:0] partial;

    // Sum of the multiplicand shifted by each set bit of the current digit.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) partial = partial + (mcand << i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= {32'd0, a};
            mplier <= b;
            prod   <= '0;
            count  <= '0;
        end else if (step) begin
            prod   <= prod + partial;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            count  <= count + 6'd1;
        end
    end

    assign last = (count == 6'(ITER - 1));

endmodule

// File: rtl/hilo_mult_unit.sv
// Multi-cycle MULT/MULTU/MUL(/MADD/MSUB) unit owning HI/LO, with Start/Busy/Done handshake.
// Define MULT_ACCUM_EN to enable MADD/MSUB; otherwise those codes are ignored.
module hilo_mult_unit
    import alu_ctrl_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1,
    parameter int WIDTH          = XLEN
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [4:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] Result
);
    hilo_state_e state, state_next;
    logic [4:0]  op_q;
    logic        neg_q;
    logic        accept;
    logic        signed_op;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod, p;
    logic        last;

    function automatic logic is_legal(input logic [4:0] code);
`ifdef MULT_ACCUM_EN
        return (code == ALU_MULT) || (code == ALU_MULTU) || (code == ALU_MUL) ||
               (code == ALU_MADD) || (code == ALU_MSUB);
`else
        return (code == ALU_MULT) || (code == ALU_MULTU) || (code == ALU_MUL);
`endif
    endfunction

    assign accept    = (state == IDLE) && Start && is_legal(ALUControl);
    assign signed_op = (ALUControl != ALU_MULTU);
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign a_mag     = (signed_op && A[31]) ? (32'd0 - A) : A;
    assign b_mag     = (signed_op && B[31]) ? (32'd0 - B) : B;
    assign p         = neg_q ? (64'd0 - prod) : prod;

    mult_shift_add_core #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_core (
        .clk  (Clk),
        .rst  (Rst),
        .load (accept),
        .step (state == CALC),
        .a    (a_mag),
        .b    (b_mag),
        .prod (prod),
        .last (last)
    );

`ifdef MULT_ACCUM_EN
    logic [63:0] acc_sum, acc_diff;
    assign acc_sum  = {Hi, Lo} + p;
    assign acc_diff = {Hi, Lo} - p;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: if (last) state_next = ACC;
            ACC:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Busy tracks CALC/ACC exactly; Done is registered off DONE, so it pulses while IDLE.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state  <= IDLE;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
            Result <= '0;
            op_q   <= ALU_MULT;
            neg_q  <= 1'b0;
        end else begin
            state <= state_next;
            Busy  <= (state_next == CALC) || (state_next == ACC);
            Done  <= (state == DONE);
            if (accept) begin
                op_q  <= ALUControl;
                neg_q <= signed_op && (A[31] ^ B[31]);
            end
            if (state == ACC) begin
                case (op_q)
                    ALU_MULT, ALU_MULTU: {Hi, Lo} <= p;
`ifdef MULT_ACCUM_EN
                    ALU_MADD:            {Hi, Lo} <= acc_sum;
                    ALU_MSUB:            {Hi, Lo} <= acc_diff;
`endif
                    ALU_MUL:             Result   <= p[31:0];
                    default: ;
                endcase
            end else begin
                if (HiWrite) Hi <= WriteData;
                if (LoWrite) Lo <= WriteData;
            end
        end
    end

endmodule
